// File: rtl/sa_output_deskew_if.sv
// Result-bus and writeback-handshake bundle of the systolic-array output deskew collector.
// The slave modport is the collector's own view; master is the surrounding array/writeback side.
interface sa_output_deskew_if #(
  parameter int MATRIX_SIZE = 8,
  parameter int PSUM_BW     = 20,
  parameter int OUT_BW      = 16,
  parameter int FIFO_DEPTH  = 4
);
  logic                            in_valid;
  logic [MATRIX_SIZE*PSUM_BW-1:0]  RESULTS;
  logic                            out_ready;
  logic                            out_valid;
  logic [MATRIX_SIZE*OUT_BW-1:0]   DOUT;
  logic                            tile_done;
  logic                            overflow;
  logic [$clog2(FIFO_DEPTH):0]     fifo_count;

  modport master (
    output in_valid, RESULTS, out_ready,
    input  out_valid, DOUT, tile_done, overflow, fifo_count
  );

  modport slave (
    input  in_valid, RESULTS, out_ready,
    output out_valid, DOUT, tile_done, overflow, fifo_count
  );
endinterface

// File: rtl/sa_output_deskew.sv
// Realigns the row-skewed partial sums leaving the systolic array into whole vectors,
// saturates them and queues them in a small FIFO drained by a valid/ready handshake.
module sa_output_deskew #(
  parameter int MATRIX_SIZE = 8,
  parameter int PSUM_BW     = 20,
  parameter int OUT_BW      = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  sa_output_deskew_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TILE_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam int VEC_W  = MATRIX_SIZE * OUT_BW;

  logic signed [PSUM_BW-1:0] aligned [MATRIX_SIZE];
  logic [VEC_W-1:0]          sat_vec;
  logic [MATRIX_SIZE-2:0]    vld_q, vld_d;
  logic [VEC_W-1:0]          mem_q [FIFO_DEPTH];
  logic [VEC_W-1:0]          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [TILE_W-1:0]         tile_cnt_q, tile_cnt_d;
  logic                      tile_done_q, tile_done_d;
  logic                      overflow_q, overflow_d;
  logic                      push, pop, full, accept, out_valid;

  // In range exactly when every bit from the output sign bit upward agrees.
  function automatic logic [OUT_BW-1:0] saturate(input logic signed [PSUM_BW-1:0] v);
    logic [PSUM_BW-OUT_BW:0] upper;
    upper = v[PSUM_BW-1:OUT_BW-1];
    if ((&upper) || (~|upper)) return v[OUT_BW-1:0];
    else if (v[PSUM_BW-1])     return {1'b1, {(OUT_BW-1){1'b0}}};
    else                       return {1'b0, {(OUT_BW-1){1'b1}}};
  endfunction

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_row
    localparam int DEPTH = MATRIX_SIZE - 1 - i;
    logic signed [PSUM_BW-1:0] lane_in;
    assign lane_in = bus.RESULTS[(MATRIX_SIZE-i-1)*PSUM_BW +: PSUM_BW];

    if (DEPTH == 0) begin : g_direct
      assign aligned[i] = lane_in;
    end else begin : g_delay
      logic signed [PSUM_BW-1:0] dly_q [DEPTH];
      logic signed [PSUM_BW-1:0] dly_d [DEPTH];

      always_comb begin
        dly_d[0] = lane_in;
        for (int k = 1; k < DEPTH; k++) dly_d[k] = dly_q[k-1];
      end

      always_ff @(posedge clk) begin
        dly_q <= dly_d;
      end

      assign aligned[i] = dly_q[DEPTH-1];
    end
  end

  always_comb begin
    sat_vec = '0;
    for (int i = 0; i < MATRIX_SIZE; i++)
      sat_vec[(MATRIX_SIZE-i-1)*OUT_BW +: OUT_BW] = saturate(aligned[i]);
  end

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = bus.in_valid;
    for (int k = 1; k < MATRIX_SIZE - 1; k++) vld_d[k] = vld_q[k-1];
  end

  // A full FIFO still accepts when it pops in the same cycle; otherwise the vector is dropped.
  always_comb begin
    out_valid   = (count_q != '0);
    pop         = out_valid && bus.out_ready;
    full        = (count_q == CNT_W'(FIFO_DEPTH));
    push        = vld_q[MATRIX_SIZE-2];
    accept      = push && (!full || pop);
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tile_cnt_d  = tile_cnt_q;
    tile_done_d = 1'b0;
    if (accept) begin
      mem_d[wr_ptr_q] = sat_vec;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (tile_cnt_q == TILE_W'(MATRIX_SIZE - 1)) begin
        tile_cnt_d  = '0;
        tile_done_d = 1'b1;
      end else begin
        tile_cnt_d = tile_cnt_q + TILE_W'(1);
      end
    end
    count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
    overflow_d = overflow_q | (push && full && !pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tile_cnt_q  <= '0;
      tile_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tile_cnt_q  <= tile_cnt_d;
      tile_done_q <= tile_done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.DOUT       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.tile_done  = tile_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_sa_output_deskew.sv
// Self-checking bench for sa_output_deskew: directed scenarios plus a randomized run
// compared every cycle against a queue-based model of the aligned-vector stream.
module tb_sa_output_deskew;
  localparam int M  = 8;
  localparam int P  = 20;
  localparam int O  = 16;
  localparam int F  = 4;
  localparam int CW = $clog2(F) + 1;

  typedef logic [M*P-1:0] rvec_t;
  typedef logic [M*O-1:0] ovec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sa_output_deskew_if #(.MATRIX_SIZE(M), .PSUM_BW(P), .OUT_BW(O), .FIFO_DEPTH(F)) bus();

  sa_output_deskew #(.MATRIX_SIZE(M), .PSUM_BW(P), .OUT_BW(O), .FIFO_DEPTH(F)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cur   = 0;
  bit    iss_v   [int];
  rvec_t iss_vec [int];
  ovec_t exp_q [$];
  bit    exp_tile = 1'b0;
  bit    exp_ovf  = 1'b0;
  int    pops     = 0;
  bit    m_pop;
  int    m_sz, m_src;

  function automatic ovec_t sat_vec(input rvec_t v);
    ovec_t r;
    logic signed [P-1:0] row;
    int x;
    r = '0;
    for (int i = 0; i < M; i++) begin
      row = v[(M-i-1)*P +: P];
      x = row;
      if (x > 32767) x = 32767;
      else if (x < -32768) x = -32768;
      r[(M-i-1)*O +: O] = x[O-1:0];
    end
    return r;
  endfunction

  function automatic rvec_t rand_vec();
    rvec_t r;
    int x;
    r = '0;
    for (int i = 0; i < M; i++) begin
      case ($urandom_range(0, 3))
        0:       x = int'($urandom_range(0, 65535)) - 32768;
        1:       x = int'($urandom_range(32760, 524287));
        2:       x = -int'($urandom_range(32760, 524288));
        default: x = int'($urandom_range(0, 1048575)) - 524288;
      endcase
      r[(M-i-1)*P +: P] = x[P-1:0];
    end
    return r;
  endfunction

  function automatic ovec_t model_dout();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  // Reference: a vector issued in cycle c becomes a write at the edge closing cycle c+M-1.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
      iss_v.delete();
      iss_vec.delete();
      exp_tile = 1'b0;
      exp_ovf  = 1'b0;
      pops     = 0;
    end else begin
      m_sz     = exp_q.size();
      m_pop    = (m_sz > 0) && bus.out_ready;
      exp_tile = 1'b0;
      if (m_pop) begin
        void'(exp_q.pop_front());
        pops++;
        if (pops % M == 0) exp_tile = 1'b1;
      end
      m_src = cur - (M - 1);
      if (iss_v.exists(m_src)) begin
        if (m_sz == F && !m_pop) exp_ovf = 1'b1;
        else exp_q.push_back(sat_vec(iss_vec[m_src]));
      end
    end
  end

  // Drives one cycle: row i shows the vector issued i cycles earlier, else random filler.
  task automatic tick(input bit v, input rvec_t vec, input bit rdy);
    rvec_t r, tmp;
    if (v) begin
      iss_v[cur]   = 1'b1;
      iss_vec[cur] = vec;
    end
    for (int i = 0; i < M; i++) begin
      if (iss_v.exists(cur - i)) begin
        tmp = iss_vec[cur - i];
        r[(M-i-1)*P +: P] = tmp[(M-i-1)*P +: P];
      end else begin
        r[(M-i-1)*P +: P] = P'($urandom);
      end
    end
    bus.in_valid  = v;
    bus.RESULTS   = r;
    bus.out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    cur++;
  endtask

  task automatic apply_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cur++;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.RESULTS   = '0;
    bus.out_ready = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.DOUT !== '0) begin n_bad++; $display("[TB] FAIL reset_dout: got %h expected 0", bus.DOUT); end
    n_cmp++; if (bus.tile_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_tile_done: got %b expected 0", bus.tile_done); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); end
    n_cmp++; if (bus.fifo_count !== CW'(0)) begin n_bad++; $display("[TB] FAIL reset_fifo_count: got %0d expected 0", bus.fifo_count); end
    rstn = 1'b1;
  endtask

  task automatic test_single();
    rvec_t v;
    ovec_t e;
    for (int i = 0; i < M; i++) begin
      v[(M-i-1)*P +: P] = P'(i + 1);
      e[(M-i-1)*O +: O] = O'(i + 1);
    end
    tick(1'b1, v, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      n_cmp++;
      if (bus.out_valid !== 1'(k == M)) begin
        n_bad++; $display("[TB] FAIL single_valid cycle t+%0d: got %b expected %b", k, bus.out_valid, (k == M));
      end
      if (k == M) begin
        n_cmp++;
        if (bus.DOUT !== e) begin n_bad++; $display("[TB] FAIL single_dout: got %h expected %h", bus.DOUT, e); end
      end
      tick(1'b0, '0, 1'b1);
    end
    n_cmp++;
    if (bus.fifo_count !== CW'(0)) begin n_bad++; $display("[TB] FAIL single_count: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_back_to_back();
    rvec_t v [M];
    ovec_t e [M];
    int c1;
    apply_reset();
    for (int k = 0; k < M; k++)
      for (int i = 0; i < M; i++) begin
        v[k][(M-i-1)*P +: P] = P'(16*k + i);
        e[k][(M-i-1)*O +: O] = O'(16*k + i);
      end
    for (int c = 0; c < 20; c++) begin
      tick(c < M, (c < M) ? v[c] : '0, 1'b1);
      c1 = c + 1;
      n_cmp++;
      if (bus.out_valid !== 1'(c1 >= M && c1 < 2*M)) begin
        n_bad++; $display("[TB] FAIL b2b_valid cycle t+%0d: got %b", c1, bus.out_valid);
      end
      if (c1 >= M && c1 < 2*M) begin
        n_cmp++;
        if (bus.DOUT !== e[c1-M]) begin n_bad++; $display("[TB] FAIL b2b_dout vec %0d: got %h expected %h", c1-M, bus.DOUT, e[c1-M]); end
      end
      n_cmp++;
      if (bus.tile_done !== 1'(c1 == 2*M)) begin
        n_bad++; $display("[TB] FAIL b2b_tile_done cycle t+%0d: got %b expected %b", c1, bus.tile_done, (c1 == 2*M));
      end
    end
  endtask

  task automatic test_saturation();
    rvec_t v;
    ovec_t e;
    int lim [4];
    lim = '{32767, -32768, -32768, 32767};
    v = rand_vec();
    v[(M-1)*P +: P] = P'(32768);
    v[(M-2)*P +: P] = P'(-40000);
    v[(M-3)*P +: P] = P'(-32768);
    v[(M-4)*P +: P] = P'(32767);
    e = sat_vec(v);
    tick(1'b1, v, 1'b1);
    for (int k = 1; k <= M; k++) begin
      if (k == M) begin
        for (int i = 0; i < 4; i++) begin
          n_cmp++;
          if (bus.DOUT[(M-i-1)*O +: O] !== O'(lim[i])) begin
            n_bad++; $display("[TB] FAIL sat_lane%0d: got %h expected %h", i, bus.DOUT[(M-i-1)*O +: O], O'(lim[i]));
          end
        end
        n_cmp++;
        if (bus.DOUT !== e) begin n_bad++; $display("[TB] FAIL sat_vector: got %h expected %h", bus.DOUT, e); end
      end
      tick(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_overflow();
    rvec_t v [5];
    int got;
    apply_reset();
    for (int k = 0; k < 5; k++) v[k] = rand_vec();
    for (int c = 0; c < 12; c++) begin
      tick(c < 5, (c < 5) ? v[c] : '0, 1'b0);
      if (c + 1 == 11 || c + 1 == 12) begin
        n_cmp++;
        if (bus.fifo_count !== CW'(F)) begin n_bad++; $display("[TB] FAIL ovf_count cycle t+%0d: got %0d expected %0d", c+1, bus.fifo_count, F); end
        n_cmp++;
        if (bus.overflow !== 1'(c + 1 == 12)) begin n_bad++; $display("[TB] FAIL ovf_flag cycle t+%0d: got %b expected %b", c+1, bus.overflow, (c+1 == 12)); end
      end
    end
    got = 0;
    for (int d = 0; d < 10; d++) begin
      if (bus.out_valid === 1'b1) begin
        if (got < F) begin
          n_cmp++;
          if (bus.DOUT !== sat_vec(v[got])) begin n_bad++; $display("[TB] FAIL ovf_drain vec %0d: got %h expected %h", got, bus.DOUT, sat_vec(v[got])); end
        end
        got++;
      end
      tick(1'b0, '0, 1'b1);
    end
    n_cmp++;
    if (got != F) begin n_bad++; $display("[TB] FAIL ovf_drain_count: got %0d expected %0d", got, F); end
    n_cmp++;
    if (bus.overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_sticky: got %b expected 1", bus.overflow); end
  endtask

  task automatic test_mid_reset();
    rvec_t v;
    ovec_t e;
    for (int c = 0; c < 9; c++) tick(c < 5, rand_vec(), 1'b0);
    n_cmp++;
    if (bus.fifo_count !== CW'(2)) begin n_bad++; $display("[TB] FAIL midrst_pre_count: got %0d expected 2", bus.fifo_count); end
    n_cmp++;
    if (bus.overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_pre_overflow: got %b expected 1", bus.overflow); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.fifo_count !== CW'(0)) begin n_bad++; $display("[TB] FAIL midrst_count: got %0d expected 0", bus.fifo_count); end
    n_cmp++; if (bus.tile_done !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_tile_done: got %b expected 0", bus.tile_done); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_overflow: got %b expected 0", bus.overflow); end
    @(posedge clk);
    @(negedge clk);
    cur++;
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, '0, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_stale cycle %0d: got out_valid %b expected 0", c, bus.out_valid); end
    end
    v = rand_vec();
    e = sat_vec(v);
    tick(1'b1, v, 1'b1);
    for (int k = 1; k <= M; k++) begin
      n_cmp++;
      if (bus.out_valid !== 1'(k == M)) begin n_bad++; $display("[TB] FAIL midrst_new_valid t+%0d: got %b expected %b", k, bus.out_valid, (k == M)); end
      if (k == M) begin
        n_cmp++;
        if (bus.DOUT !== e) begin n_bad++; $display("[TB] FAIL midrst_new_dout: got %h expected %h", bus.DOUT, e); end
      end
      tick(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_full_pop();
    rvec_t v [5];
    int got;
    apply_reset();
    for (int k = 0; k < 5; k++) v[k] = rand_vec();
    for (int c = 0; c < 11; c++) tick(c < 5, (c < 5) ? v[c] : '0, 1'b0);
    n_cmp++;
    if (bus.fifo_count !== CW'(F)) begin n_bad++; $display("[TB] FAIL fullpop_pre_count: got %0d expected %0d", bus.fifo_count, F); end
    got = 0;
    for (int d = 0; d < 10; d++) begin
      if (bus.out_valid === 1'b1) begin
        if (got < 5) begin
          n_cmp++;
          if (bus.DOUT !== sat_vec(v[got])) begin n_bad++; $display("[TB] FAIL fullpop_drain vec %0d: got %h expected %h", got, bus.DOUT, sat_vec(v[got])); end
        end
        got++;
      end
      tick(1'b0, '0, 1'b1);
      if (d == 0) begin
        n_cmp++;
        if (bus.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL fullpop_overflow: got %b expected 0", bus.overflow); end
        n_cmp++;
        if (bus.fifo_count !== CW'(F)) begin n_bad++; $display("[TB] FAIL fullpop_count: got %0d expected %0d", bus.fifo_count, F); end
      end
    end
    n_cmp++;
    if (got != 5) begin n_bad++; $display("[TB] FAIL fullpop_drain_count: got %0d expected 5", got); end
  endtask

  task automatic test_random();
    bit v, rdy;
    apply_reset();
    for (int c = 0; c < 420; c++) begin
      v   = (c < 400) && ($urandom_range(0, 3) != 0);
      rdy = (c >= 400) || ($urandom_range(0, 2) != 0);
      tick(v, rand_vec(), rdy);
      n_cmp++;
      if (bus.out_valid !== 1'(exp_q.size() != 0)) begin n_bad++; $display("[TB] FAIL rnd_valid cyc %0d: got %b expected %b", c, bus.out_valid, (exp_q.size() != 0)); end
      n_cmp++;
      if (bus.DOUT !== model_dout()) begin n_bad++; $display("[TB] FAIL rnd_dout cyc %0d: got %h expected %h", c, bus.DOUT, model_dout()); end
      n_cmp++;
      if (bus.fifo_count !== CW'(exp_q.size())) begin n_bad++; $display("[TB] FAIL rnd_count cyc %0d: got %0d expected %0d", c, bus.fifo_count, exp_q.size()); end
      n_cmp++;
      if (bus.tile_done !== exp_tile) begin n_bad++; $display("[TB] FAIL rnd_tile_done cyc %0d: got %b expected %b", c, bus.tile_done, exp_tile); end
      n_cmp++;
      if (bus.overflow !== exp_ovf) begin n_bad++; $display("[TB] FAIL rnd_overflow cyc %0d: got %b expected %b", c, bus.overflow, exp_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_overflow();
    test_mid_reset();
    test_full_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
